// File: rtl/cs_sched_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cs_sched_pkg: chip-select codes, sequencer states, code mapping.  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package cs_sched_pkg;

  localparam int          CS_CODE_WIDTH   = 5;
  localparam logic [4:0]  CS_CODE_NONE    = 5'h00;
  localparam logic [4:0]  CS_CODE_FLASH   = 5'h1D;
  localparam logic [4:0]  CS_CODE_MAX3421 = 5'h1E;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SEL_SETUP  = 3'd1,
    ST_SEL_STROBE = 3'd2,
    ST_ACTIVE     = 3'd3,
    ST_REL_SETUP  = 3'd4,
    ST_REL_STROBE = 3'd5,
    ST_GUARD      = 3'd6
  } state_e;

  // Slots 0..13 map to codes 1..14; the two fixed devices sit at the top of the code space.
  function automatic logic [4:0] tgt_to_code(input logic [3:0] tgt);
    logic [4:0] code;
    if (tgt == 4'd14) begin
      code = CS_CODE_FLASH;
    end else if (tgt == 4'd15) begin
      code = CS_CODE_MAX3421;
    end else begin
      code = {1'b0, tgt} + 5'd1;
    end
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cs_sequencer_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cs_sequencer_if: request/grant and decoder-side bus of sequencer. |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
interface cs_sequencer_if #(
  parameter int NUM_TGT     = 16,
  parameter int CS_IN_WIDTH = 5
);
  logic [NUM_TGT-1:0]     req;
  logic                   done;
  logic [NUM_TGT-1:0]     grant;
  logic [CS_IN_WIDTH-1:0] cs_code;
  logic                   cs_ready;
  logic                   busy;
  logic                   timeout_err;

  modport master (
    output req, done,
    input  grant, cs_code, cs_ready, busy, timeout_err
  );

  modport slave (
    input  req, done,
    output grant, cs_code, cs_ready, busy, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arbiter: round-robin pointer with one-hot and indexed winner.  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module rr_arbiter #(
  parameter int NUM_TGT = 16,
  parameter int IW      = $clog2(NUM_TGT)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NUM_TGT-1:0] req_i,
  input  logic               load_i,
  output logic               valid_o,
  output logic [IW-1:0]      idx_o,
  output logic [NUM_TGT-1:0] onehot_o
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] cand;
  logic          found;

  // Search starts one past the last winner; the power-of-two target count makes the wrap free.
  always_comb begin
    found    = 1'b0;
    idx_o    = '0;
    cand     = '0;
    for (int i = 1; i <= NUM_TGT; i++) begin
      cand = ptr_q + IW'(i);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = cand;
      end
    end
    valid_o  = found;
    onehot_o = found ? (NUM_TGT'(1) << idx_o) : '0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptr_q <= IW'(NUM_TGT - 1);
    end else if (load_i) begin
      ptr_q <= idx_o;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cs_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cs_sequencer: round-robin chip-select scheduler driving the CPLD  |
// | decoder code bus and latch strobe. Revision: 1.0                  |
// +------------------------------------------------------------------+
module cs_sequencer
  import cs_sched_pkg::*;
#(
  parameter int NUM_TGT     = 16,
  parameter int CS_IN_WIDTH = 5,
  parameter int STROBE_CYC  = 2,
  parameter int GUARD_CYC   = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic          clk,
  input  logic          resetn,
  cs_sequencer_if.slave bus
);

  localparam int          IW           = $clog2(NUM_TGT);
  localparam logic [15:0] STROBE_LAST  = 16'(STROBE_CYC - 1);
  localparam logic [15:0] GUARD_LAST   = 16'(GUARD_CYC - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

  state_e                 state_q, state_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [IW-1:0]          winner_q, winner_d;
  logic [NUM_TGT-1:0]     winner_oh_q, winner_oh_d;
  logic [CS_IN_WIDTH-1:0] cs_code_q, cs_code_d;
  logic                   cs_ready_q, cs_ready_d;
  logic [NUM_TGT-1:0]     grant_q, grant_d;
  logic                   busy_q, busy_d;
  logic                   timeout_err_q, timeout_err_d;

  logic                   arb_valid;
  logic [IW-1:0]          arb_idx;
  logic [NUM_TGT-1:0]     arb_onehot;
  logic                   arb_load;

  rr_arbiter #(
    .NUM_TGT (NUM_TGT),
    .IW      (IW)
  ) u_arb (
    .clk      (clk),
    .resetn   (resetn),
    .req_i    (bus.req),
    .load_i   (arb_load),
    .valid_o  (arb_valid),
    .idx_o    (arb_idx),
    .onehot_o (arb_onehot)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    winner_d      = winner_q;
    winner_oh_d   = winner_oh_q;
    arb_load      = 1'b0;
    timeout_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d     = ST_SEL_SETUP;
          winner_d    = arb_idx;
          winner_oh_d = arb_onehot;
          arb_load    = 1'b1;
          cnt_d       = '0;
        end
      end
      ST_SEL_SETUP: begin
        state_d = ST_SEL_STROBE;
        cnt_d   = '0;
      end
      ST_SEL_STROBE: begin
        if (cnt_q == STROBE_LAST) begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_ACTIVE: begin
        // done wins over a coincident timeout, so no error is flagged then.
        if (bus.done) begin
          state_d = ST_REL_SETUP;
          cnt_d   = '0;
        end else if ((TIMEOUT_CYC != 0) && (cnt_q == TIMEOUT_LAST)) begin
          state_d       = ST_REL_SETUP;
          cnt_d         = '0;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_REL_SETUP: begin
        state_d = ST_REL_STROBE;
        cnt_d   = '0;
      end
      ST_REL_STROBE: begin
        if (cnt_q == STROBE_LAST) begin
          state_d = (GUARD_CYC == 0) ? ST_IDLE : ST_GUARD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so every output leaves a flop.
    cs_code_d  = CS_IN_WIDTH'(CS_CODE_NONE);
    if (state_d inside {ST_SEL_SETUP, ST_SEL_STROBE, ST_ACTIVE}) begin
      cs_code_d = CS_IN_WIDTH'(tgt_to_code(4'(winner_d)));
    end
    cs_ready_d = state_d inside {ST_SEL_STROBE, ST_REL_STROBE};
    grant_d    = (state_d == ST_ACTIVE) ? winner_oh_d : '0;
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      winner_q      <= '0;
      winner_oh_q   <= '0;
      cs_code_q     <= '0;
      cs_ready_q    <= 1'b0;
      grant_q       <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      winner_q      <= winner_d;
      winner_oh_q   <= winner_oh_d;
      cs_code_q     <= cs_code_d;
      cs_ready_q    <= cs_ready_d;
      grant_q       <= grant_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.cs_code     = cs_code_q;
  assign bus.cs_ready    = cs_ready_q;
  assign bus.grant       = grant_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_cs_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_cs_sequencer: directed checks of select/release sequencing.    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_cs_sequencer;

  logic clk;
  logic resetn;
  int   n_chk;
  int   n_err;

  cs_sequencer_if #(.NUM_TGT(16), .CS_IN_WIDTH(5)) bus ();
  cs_sequencer_if #(.NUM_TGT(16), .CS_IN_WIDTH(5)) bus_to ();

  cs_sequencer #(
    .NUM_TGT(16), .CS_IN_WIDTH(5), .STROBE_CYC(2), .GUARD_CYC(4), .TIMEOUT_CYC(65535)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  cs_sequencer #(
    .NUM_TGT(16), .CS_IN_WIDTH(5), .STROBE_CYC(2), .GUARD_CYC(4), .TIMEOUT_CYC(8)
  ) dut_to (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Minimal decoder: latches the code on the strobe rising edge, clears on reset.
  logic [4:0] dec_q;
  logic       flash_cs_n;
  logic       max_cs_n;
  always @(posedge bus.cs_ready or negedge resetn) begin
    if (!resetn) dec_q <= 5'h00;
    else         dec_q <= bus.cs_code;
  end
  assign flash_cs_n = (dec_q != 5'h1D);
  assign max_cs_n   = (dec_q != 5'h1E);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn      = 1'b0;
    bus.req     = '0;
    bus.done    = 1'b0;
    bus_to.req  = '0;
    bus_to.done = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  function automatic bit cond_met(input int which);
    case (which)
      0:       return bus.grant != '0;
      1:       return bus_to.grant != '0;
      2:       return !bus.busy;
      default: return !bus_to.busy;
    endcase
  endfunction

  // Bounded wait; an expired bound shows up as a failed check by the caller.
  task automatic wait_cond(input int which);
    int n = 0;
    while (!cond_met(which) && n < 100) begin
      tick();
      n++;
    end
    check("wait_bound", 32'(cond_met(which)), 32'd1);
  endtask

  logic [15:0] exp_g [4];
  logic [4:0]  exp_c [4];

  initial begin
    n_chk = 0;
    n_err = 0;
    exp_g = '{16'h0001, 16'h8000, 16'h0001, 16'h8000};
    exp_c = '{5'h01, 5'h1E, 5'h01, 5'h1E};

    // Reset values
    do_reset();
    check("rst_code",  32'(bus.cs_code),     32'h0);
    check("rst_ready", 32'(bus.cs_ready),    32'h0);
    check("rst_grant", 32'(bus.grant),       32'h0);
    check("rst_busy",  32'(bus.busy),        32'h0);
    check("rst_terr",  32'(bus.timeout_err), 32'h0);

    // Single transfer, target 0, done at cycle 10
    bus.req = 16'h0001;
    tick();
    check("s1_code_c1",  32'(bus.cs_code),  32'h01);
    check("s1_ready_c1", 32'(bus.cs_ready), 32'h0);
    check("s1_busy_c1",  32'(bus.busy),     32'h1);
    tick();
    check("s1_ready_c2", 32'(bus.cs_ready), 32'h1);
    check("s1_grant_c2", 32'(bus.grant),    32'h0);
    tick();
    check("s1_ready_c3", 32'(bus.cs_ready), 32'h1);
    check("s1_code_c3",  32'(bus.cs_code),  32'h01);
    tick();
    check("s1_grant_c4", 32'(bus.grant),    32'h0001);
    check("s1_ready_c4", 32'(bus.cs_ready), 32'h0);
    bus.req = '0;
    repeat (6) tick();
    check("s1_grant_c10", 32'(bus.grant), 32'h0001);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    check("s1_code_c11",  32'(bus.cs_code),  32'h00);
    check("s1_grant_c11", 32'(bus.grant),    32'h0);
    check("s1_ready_c11", 32'(bus.cs_ready), 32'h0);
    tick();
    check("s1_ready_c12", 32'(bus.cs_ready), 32'h1);
    tick();
    check("s1_ready_c13", 32'(bus.cs_ready), 32'h1);
    tick();
    check("s1_ready_c14", 32'(bus.cs_ready), 32'h0);
    check("s1_busy_c14",  32'(bus.busy),     32'h1);
    repeat (3) tick();
    check("s1_busy_c17", 32'(bus.busy), 32'h1);
    tick();
    check("s1_busy_c18", 32'(bus.busy), 32'h0);

    // Round-robin between targets 0 and 15
    do_reset();
    bus.req = 16'h8001;
    for (int k = 0; k < 4; k++) begin
      wait_cond(0);
      check($sformatf("rr_grant_%0d", k), 32'(bus.grant),   32'(exp_g[k]));
      check($sformatf("rr_code_%0d", k),  32'(bus.cs_code), 32'(exp_c[k]));
      repeat (3) tick();
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
    end
    bus.req = '0;
    wait_cond(2);

    // Flash and MAX3421 codes seen through the decoder
    do_reset();
    bus.req = 16'h4000;
    tick();
    check("fl_code",  32'(bus.cs_code), 32'h1D);
    check("fl_cs_c1", 32'(flash_cs_n),  32'h1);
    repeat (3) tick();
    check("fl_grant", 32'(bus.grant),   32'h4000);
    check("fl_cs_c4", 32'(flash_cs_n),  32'h0);
    bus.req  = '0;
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    wait_cond(2);
    check("fl_cs_rel", 32'(flash_cs_n), 32'h1);
    bus.req = 16'h8000;
    tick();
    check("mx_code", 32'(bus.cs_code), 32'h1E);
    repeat (3) tick();
    check("mx_grant", 32'(bus.grant), 32'h8000);
    check("mx_cs_c4", 32'(max_cs_n),  32'h0);
    bus.req  = '0;
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    wait_cond(2);
    check("mx_cs_rel", 32'(max_cs_n), 32'h1);

    // Timeout after 8 ACTIVE cycles, then next requester
    do_reset();
    bus_to.req = 16'h0004;
    tick();
    check("to_code_c1", 32'(bus_to.cs_code), 32'h03);
    repeat (3) tick();
    check("to_grant_c4", 32'(bus_to.grant), 32'h0004);
    bus_to.req = 16'h0008;
    repeat (7) tick();
    check("to_grant_c11", 32'(bus_to.grant),       32'h0004);
    check("to_terr_c11",  32'(bus_to.timeout_err), 32'h0);
    tick();
    check("to_terr_c12",  32'(bus_to.timeout_err), 32'h1);
    check("to_grant_c12", 32'(bus_to.grant),       32'h0);
    check("to_code_c12",  32'(bus_to.cs_code),     32'h00);
    tick();
    check("to_terr_c13", 32'(bus_to.timeout_err), 32'h0);
    wait_cond(1);
    check("to_next_grant", 32'(bus_to.grant),   32'h0008);
    check("to_next_code",  32'(bus_to.cs_code), 32'h04);
    bus_to.req  = '0;
    bus_to.done = 1'b1;
    tick();
    bus_to.done = 1'b0;
    check("to_next_terr", 32'(bus_to.timeout_err), 32'h0);
    wait_cond(3);

    // Reset during ACTIVE restores outputs and first priority
    do_reset();
    bus.req = 16'h0001;
    repeat (4) tick();
    check("mr_grant", 32'(bus.grant), 32'h0001);
    resetn  = 1'b0;
    bus.req = '0;
    tick();
    check("mr_code",  32'(bus.cs_code),  32'h0);
    check("mr_ready", 32'(bus.cs_ready), 32'h0);
    check("mr_grant0", 32'(bus.grant),   32'h0);
    check("mr_busy",  32'(bus.busy),     32'h0);
    resetn  = 1'b1;
    bus.req = 16'h0003;
    tick();
    check("mr_prio_code", 32'(bus.cs_code), 32'h01);
    bus.req = '0;
    repeat (3) tick();
    check("mr_prio_grant", 32'(bus.grant), 32'h0001);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    wait_cond(2);
    bus.req = 16'h0002;
    tick();
    check("mr_code2", 32'(bus.cs_code), 32'h02);
    bus.req = '0;
    repeat (3) tick();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    wait_cond(2);

    // Stray done pulses and dropped request after commit
    do_reset();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    check("sd_idle_busy", 32'(bus.busy),    32'h0);
    check("sd_idle_code", 32'(bus.cs_code), 32'h0);
    bus.req = 16'h0020;
    tick();
    bus.req = '0;
    check("sd_code_c1", 32'(bus.cs_code), 32'h06);
    tick();
    bus.done = 1'b1;
    check("sd_ready_c2", 32'(bus.cs_ready), 32'h1);
    tick();
    bus.done = 1'b0;
    check("sd_ready_c3", 32'(bus.cs_ready), 32'h1);
    check("sd_code_c3",  32'(bus.cs_code),  32'h06);
    tick();
    check("sd_grant_c4", 32'(bus.grant), 32'h0020);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    wait_cond(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/cs_sequencer.md
# cs_sequencer

Synchronous scheduler that owns the 5-bit chip-select code bus and the CS_READY strobe feeding the CPLD chip-select decoder. It arbitrates round-robin between 16 SPI targets (slots 1a–7b, flash, MAX3421) and launches the select code with guaranteed setup before the strobe. It holds the selection until the owner signals completion or a timeout expires, then issues the all-deselect code and enforces a minimum deselect gap. It sits between the MCU-facing request logic and the decoder.

## Interface
- NUM_TGT, 16: number of targets; fixed mapping, not meant to change.
- CS_IN_WIDTH, 5: width of the code bus.
- STROBE_CYC, 2: cycles cs_ready is held high per strobe; must be ≥1.
- GUARD_CYC, 4: minimum idle cycles after a deselect strobe; 0 allowed.
- TIMEOUT_CYC, 65535: maximum ACTIVE cycles; 0 disables the timeout. 16-bit counter.

Ports:
- clk  in  1  system clock, 100 MHz.
- resetn  in  1  one clock; reset is synchronous and active-low.
- req  in  NUM_TGT  per-target request level; bit 14 = flash, bit 15 = MAX3421.
- done  in  1  one-cycle end-of-transfer pulse from the current owner.
- grant  out  NUM_TGT  one-hot; high only in ACTIVE.
- cs_code  out  CS_IN_WIDTH  code to the decoder.
- cs_ready  out  1  decoder latch strobe; the decoder latches on the rising edge.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  one-cycle pulse when a timeout forces release.

## Operation
- Code map:
  - target i<14 → i+1.
  - target 14 → 5'h1D.
  - target 15 → 5'h1E.
  - deselect → 5'h00.
- States: IDLE → SEL_SETUP → SEL_STROBE → ACTIVE → REL_SETUP → REL_STROBE → GUARD → IDLE.
- IDLE:
  - If any req bit is high, pick a winner by round-robin starting at (last_winner+1) mod 16.
  - Latch the winner, go to SEL_SETUP.
  - The pointer resets so target 0 has first priority.
- SEL_SETUP: cs_code = winner code, cs_ready = 0, for 1 cycle.
- SEL_STROBE: cs_ready = 1 for STROBE_CYC cycles; code held.
- ACTIVE:
  - grant[winner] = 1; code held; cs_ready = 0.
  - Exit on done, or when the counter reaches TIMEOUT_CYC. Timeout pulses timeout_err in the first REL_SETUP cycle.
  - done and timeout in the same cycle counts as done; no error.
- REL_SETUP: cs_code = 5'h00, grant = 0, for 1 cycle.
- REL_STROBE: cs_ready = 1 for STROBE_CYC cycles.
- GUARD: GUARD_CYC cycles with outputs idle, then IDLE. GUARD_CYC = 0 goes straight to IDLE.
- The transaction is committed once SEL_SETUP is entered. Dropping req afterwards has no effect.
- req changes outside IDLE are ignored; they are re-sampled at the next IDLE.
- done outside ACTIVE is ignored.

## Timing
- Reset values (resetn low at an edge, including mid-operation): cs_code = 0, cs_ready = 0, grant = 0, busy = 0, timeout_err = 0, state = IDLE, pointer = 15, counters = 0.
- The decoder shares resetn asynchronously, so it deselects concurrently.
- cs_code is stable 1 cycle before the cs_ready rising edge, through the strobe, and 1 cycle after its falling edge.
- All outputs are registered.
- Select latency: with req sampled in IDLE at cycle 0, the code appears in cycle 1, cs_ready is high in cycles 2..1+STROBE_CYC, and grant appears at cycle 2+STROBE_CYC.
- Release: with done sampled in cycle D, REL_SETUP is cycle D+1, the strobe spans D+2..D+1+STROBE_CYC, then GUARD, then IDLE. A new code appears no earlier than 1 cycle after IDLE.

## Structure
- Shared package cs_sched_pkg holds:
  - the CS_CODE_NONE/FLASH/MAX3421 constants;
  - the state encoding;
  - the tgt_to_code function.
- The decoder uses the same constants.
- Sub-module rr_arbiter (NUM_TGT): round-robin pointer plus one-hot winner, with a load enable for the update.

## Test plan
- req=16'h0001, done at cycle 10:
  - cs_code 5'h01 from cycle 1, cs_ready high cycles 2–3, grant[0] from cycle 4.
  - cs_code 5'h00 at cycle 11, cs_ready high cycles 12–13, GUARD cycles 14–17, busy low at 18.
- req=16'h8001 held, done returned 3 cycles after each grant → grant order 0, 15, 0, 15.
- req[14] → cs_code 5'h1D; req[15] → cs_code 5'h1E; decoder FLASH_CS / MAX3421_CS go low after the strobe and high after release.
- TIMEOUT_CYC=8, no done → release after 8 ACTIVE cycles; timeout_err pulses once; next requester served normally.
- resetn low for one cycle during ACTIVE → all outputs at reset values next cycle; req=16'h0002 then gets cs_code 5'h02 with first-priority order restored.
- done pulsed in IDLE and SEL_STROBE, and req dropped during SEL_SETUP → no state change from done; the sequence still completes to grant.
